// File: rtl/mmio_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_led_pkg
//  Description : Shared constants for the memory-mapped LED controller:
//                register window width, register byte offsets, prescaler
//                width and a helper that turns a byte offset into a word
//                index inside the window.
//  Options     : LED_BLINK_EN (see mmio_led_ctrl) does not change this file.
//  Revision    : 1.0  initial release
// ============================================================================
package mmio_led_pkg;

    // Register window is 2^WIN_BITS bytes (128 bytes, 32 words).
    localparam int WIN_BITS   = 7;
    localparam int PRESCALE_W = 16;

    typedef logic [WIN_BITS-1:0] off_t;   // byte offset inside the window
    typedef logic [WIN_BITS-3:0] word_t;  // word index inside the window

    localparam off_t OFF_LED_OUT  = 7'h00;
    localparam off_t OFF_MODE     = 7'h04;
    localparam off_t OFF_BLINK    = 7'h08;
    localparam off_t OFF_PRESCALE = 7'h0C;
    localparam off_t OFF_DUTY0    = 7'h10;

    // Byte offset to word index; the two byte-lane bits are dropped.
    function automatic word_t word_idx(input off_t off);
        return off[WIN_BITS-1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_led_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_led_ctrl_if
//  Description : CPU data-bus view seen by the LED peripheral.
//                  MemWrite  - store strobe          (master -> slave)
//                  DataAdr   - byte address          (master -> slave)
//                  WriteData - store data            (master -> slave)
//                  hit       - address in window     (slave  -> master)
//                  RdData    - combinational readback(slave  -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface mmio_led_ctrl_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        hit;
    logic [31:0] RdData;

    modport master (
        output MemWrite,
        output DataAdr,
        output WriteData,
        input  hit,
        input  RdData
    );

    modport slave (
        input  MemWrite,
        input  DataAdr,
        input  WriteData,
        output hit,
        output RdData
    );
endinterface
`default_nettype wire

// File: rtl/led_pwm_timer.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_timer
//  Description : Prescaler and PWM period counter shared by all LED channels.
//                pre_cnt runs 0..prescale; each time it reaches prescale a
//                tick is issued and pwm_cnt advances. wrap marks the tick on
//                which pwm_cnt rolls over from all-ones.
//  Ports       : clk, reset (async, active high)
//                prescale    - terminal count of the prescaler
//                prescale_wr - CPU is storing PRESCALE this cycle
//                pwm_cnt     - PWM phase counter, PWM_BITS wide
//                tick, wrap  - combinational event strobes
//                phase       - blink phase (only with LED_BLINK_EN)
//  Options     : LED_BLINK_EN adds a 4-bit blink counter advanced on wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module led_pwm_timer
    import mmio_led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [PRESCALE_W-1:0] prescale,
    input  wire logic                  prescale_wr,
    output logic      [PWM_BITS-1:0]   pwm_cnt,
    output logic                       tick,
    output logic                       wrap
`ifdef LED_BLINK_EN
    ,
    output logic                       phase
`endif
);

    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [PWM_BITS-1:0]   r_pwm_cnt;

    assign tick    = (r_pre_cnt == prescale);
    assign wrap    = tick && (&r_pwm_cnt);
    assign pwm_cnt = r_pwm_cnt;

    // A PRESCALE store restarts the prescaler so the new period begins cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_cnt <= '0;
        end else if (prescale_wr || tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else if (tick) begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

`ifdef LED_BLINK_EN
    logic [3:0] r_blink_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
        end else if (wrap) begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // MSB gives 8 PWM periods high, 8 low.
    assign phase = r_blink_cnt[3];
`endif

endmodule
`default_nettype wire

// File: rtl/mmio_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_led_ctrl
//  Description : Memory-mapped LED output peripheral. Decodes a 128-byte
//                register window on the CPU data bus, holds the LED_OUT,
//                MODE, PRESCALE and per-channel DUTY registers, and drives
//                each LED either statically or from a PWM compare.
//  Ports       : clk, reset (async, active high)
//                bus  - mmio_led_ctrl_if.slave (MemWrite, DataAdr,
//                       WriteData in; hit, RdData out, both combinational)
//                led  - registered LED drive, NUM_LED wide
//  Options     : LED_BLINK_EN enables the BLINK register at offset 0x08;
//                when undefined that offset is unmapped.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_led_ctrl
    import mmio_led_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          NUM_LED   = 8,
    parameter int          PWM_BITS  = 8
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mmio_led_ctrl_if.slave          bus,
    output logic      [NUM_LED-1:0] led
);

    localparam word_t IDX_LED_OUT  = word_idx(OFF_LED_OUT);
    localparam word_t IDX_MODE     = word_idx(OFF_MODE);
    localparam word_t IDX_PRESCALE = word_idx(OFF_PRESCALE);
    localparam word_t IDX_DUTY0    = word_idx(OFF_DUTY0);
`ifdef LED_BLINK_EN
    localparam word_t IDX_BLINK    = word_idx(OFF_BLINK);
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    word_t w_word;
    logic  w_wr;
    logic  w_sel_led_out;
    logic  w_sel_mode;
    logic  w_sel_prescale;
    logic  [NUM_LED-1:0] w_sel_duty;

    assign bus.hit        = (bus.DataAdr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign w_word         = bus.DataAdr[WIN_BITS-1:2];
    assign w_wr           = bus.MemWrite && bus.hit;
    assign w_sel_led_out  = (w_word == IDX_LED_OUT);
    assign w_sel_mode     = (w_word == IDX_MODE);
    assign w_sel_prescale = (w_word == IDX_PRESCALE);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [NUM_LED-1:0]    r_led_out;
    logic [NUM_LED-1:0]    r_mode;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PWM_BITS-1:0]   r_duty [NUM_LED];
    logic [NUM_LED-1:0]    r_led;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led_out  <= '0;
            r_mode     <= '0;
            r_prescale <= '0;
        end else if (w_wr) begin
            if (w_sel_led_out)  r_led_out  <= bus.WriteData[NUM_LED-1:0];
            if (w_sel_mode)     r_mode     <= bus.WriteData[NUM_LED-1:0];
            if (w_sel_prescale) r_prescale <= bus.WriteData[PRESCALE_W-1:0];
        end
    end

`ifdef LED_BLINK_EN
    logic [NUM_LED-1:0] r_blink;
    logic               w_sel_blink;

    assign w_sel_blink = (w_word == IDX_BLINK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink <= '0;
        end else if (w_wr && w_sel_blink) begin
            r_blink <= bus.WriteData[NUM_LED-1:0];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Shared timer
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0] w_pwm_cnt;
    logic                w_tick;
    logic                w_wrap;
`ifdef LED_BLINK_EN
    logic                w_phase;
`endif

    led_pwm_timer #(
        .PWM_BITS (PWM_BITS)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .prescale    (r_prescale),
        .prescale_wr (w_wr && w_sel_prescale),
        .pwm_cnt     (w_pwm_cnt),
        .tick        (w_tick),
        .wrap        (w_wrap)
`ifdef LED_BLINK_EN
        ,
        .phase       (w_phase)
`endif
    );

    // ------------------------------------------------------------------
    // Per-channel DUTY register and channel value
    // ------------------------------------------------------------------
    logic [NUM_LED-1:0] w_chan;

    for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
        localparam word_t IDX_DUTY = IDX_DUTY0 + word_t'(i);

        assign w_sel_duty[i] = (w_word == IDX_DUTY);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_duty[i] <= '0;
            end else if (w_wr && w_sel_duty[i]) begin
                r_duty[i] <= bus.WriteData[PWM_BITS-1:0];
            end
        end

        logic w_level;
        assign w_level = r_mode[i] ? (w_pwm_cnt < r_duty[i]) : r_led_out[i];

`ifdef LED_BLINK_EN
        assign w_chan[i] = w_level && (!r_blink[i] || w_phase);
`else
        assign w_chan[i] = w_level;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led <= '0;
        end else begin
            r_led <= w_chan;
        end
    end

    assign led = r_led;

    // ------------------------------------------------------------------
    // Combinational readback; shows register contents before any store
    // landing on the coming edge.
    // ------------------------------------------------------------------
    always_comb begin
        bus.RdData = '0;
        if (bus.hit) begin
            if (w_sel_led_out)  bus.RdData[NUM_LED-1:0]    = r_led_out;
            if (w_sel_mode)     bus.RdData[NUM_LED-1:0]    = r_mode;
            if (w_sel_prescale) bus.RdData[PRESCALE_W-1:0] = r_prescale;
`ifdef LED_BLINK_EN
            if (w_sel_blink)    bus.RdData[NUM_LED-1:0]    = r_blink;
`endif
            for (int i = 0; i < NUM_LED; i++) begin
                if (w_sel_duty[i]) bus.RdData[PWM_BITS-1:0] = r_duty[i];
            end
        end
    end

    // Byte-lane bits, upper store data and the timer strobes are not needed here.
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.DataAdr[1:0], bus.WriteData, w_tick, w_wrap};

endmodule
`default_nettype wire

// File: tb/tb_mmio_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_led_ctrl
//  Description : Self-checking bench for mmio_led_ctrl (8 LEDs, 8-bit PWM).
//                Register decode vectors come from a table; readback
//                expectations go through a scoreboard queue. PWM, prescaler,
//                reset and blink behaviour use hand-written sequences.
//  Options     : LED_BLINK_EN selects the blink expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mmio_led_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] led;

    mmio_led_ctrl_if bus ();

    mmio_led_ctrl #(
        .BASE_ADDR (32'h0001_0000),
        .NUM_LED   (8),
        .PWM_BITS  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .led   (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Called at a falling edge: present a read, queue the expectation,
    // then compare the combinational readback.
    task automatic read_chk(input logic [31:0] addr, input string name, input logic [31:0] exp);
        sb_t e;
        bus.MemWrite = 1'b0;
        bus.DataAdr  = addr;
        sb_q.push_back('{name, exp});
        #1;
        e = sb_q.pop_front();
        check(e.name, bus.RdData, e.exp);
    endtask

    // Starts and ends on a falling edge.
    task automatic bus_cycle(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.MemWrite  = we;
        bus.DataAdr   = addr;
        bus.WriteData = data;
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus_cycle(1'b1, addr, data);
    endtask

    task automatic count_high(input int ncyc, output int cnt);
        cnt = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (led[0]) cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        int found;
        logic prev;

        // ---------------- decode vector table ----------------
        //            we    waddr          wdata          raddr          hit   rd
        vecs[0]  = '{1'b1, 32'h0001_0000, 32'hFFFF_FFA5, 32'h0001_0000, 1'b1, 32'h0000_00A5};
        vecs[1]  = '{1'b1, 32'h0001_0004, 32'h0000_01FF, 32'h0001_0004, 1'b1, 32'h0000_00FF};
        vecs[2]  = '{1'b1, 32'h0001_000C, 32'hDEAD_1234, 32'h0001_000C, 1'b1, 32'h0000_1234};
        vecs[3]  = '{1'b1, 32'h0001_0010, 32'hFFFF_FF40, 32'h0001_0010, 1'b1, 32'h0000_0040};
        vecs[4]  = '{1'b1, 32'h0001_002C, 32'h0000_0180, 32'h0001_002C, 1'b1, 32'h0000_0080};
        vecs[5]  = '{1'b1, 32'h0001_0030, 32'h0000_0055, 32'h0001_0030, 1'b1, 32'h0000_0000};
        vecs[6]  = '{1'b1, 32'h0001_0070, 32'h0000_FFFF, 32'h0001_0070, 1'b1, 32'h0000_0000};
`ifdef LED_BLINK_EN
        vecs[7]  = '{1'b1, 32'h0001_0008, 32'h0000_01FF, 32'h0001_0008, 1'b1, 32'h0000_00FF};
`else
        vecs[7]  = '{1'b1, 32'h0001_0008, 32'h0000_01FF, 32'h0001_0008, 1'b1, 32'h0000_0000};
`endif
        vecs[8]  = '{1'b0, 32'h0001_0000, 32'h0000_0011, 32'h0000_0040, 1'b0, 32'h0000_0000};
        vecs[9]  = '{1'b0, 32'h0001_0000, 32'h0000_0011, 32'h0001_0000, 1'b1, 32'h0000_00A5};
        vecs[10] = '{1'b1, 32'h0001_0003, 32'h0000_003C, 32'h0001_0000, 1'b1, 32'h0000_003C};
        vecs[11] = '{1'b1, 32'h0002_0000, 32'h0000_0077, 32'h0001_0000, 1'b1, 32'h0000_003C};
        vecs[12] = '{1'b1, 32'h0001_0080, 32'h0000_0099, 32'h0001_0080, 1'b0, 32'h0000_0000};
        vecs[13] = '{1'b1, 32'h0001_0013, 32'h0000_0022, 32'h0001_0010, 1'b1, 32'h0000_0022};
        vecs[14] = '{1'b1, 32'hFFFF_0004, 32'h0000_0000, 32'h0001_0004, 1'b1, 32'h0000_00FF};
        vecs[15] = '{1'b1, 32'h0001_000F, 32'h0000_0000, 32'h0001_000C, 1'b1, 32'h0000_0000};

        // ---------------- reset state ----------------
        reset         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = '0;
        bus.WriteData = '0;
        repeat (3) @(negedge clk);
        check("reset_led", led, 8'h00);
        read_chk(32'h0001_0000, "reset_rd_led_out", 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- table-driven decode ----------------
        for (int v = 0; v < 16; v++) begin
            bus_cycle(vecs[v].we, vecs[v].waddr, vecs[v].wdata);
            bus.DataAdr = vecs[v].raddr;
            #1;
            check($sformatf("vec%0d_hit", v), bus.hit, vecs[v].exp_hit);
            read_chk(vecs[v].raddr, $sformatf("vec%0d_rd", v), vecs[v].exp_rd);
        end
`ifdef LED_BLINK_EN
        bus_write(32'h0001_0008, 32'h0);
`endif

        // ---------------- static output latency ----------------
        bus_write(32'h0001_0004, 32'h0);
        bus_write(32'h0001_0000, 32'h3C);
        @(negedge clk);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = 32'h0001_0000;
        bus.WriteData = 32'h0000_00A5;
        #1;
        check("rd_ignores_same_cycle_store", bus.RdData, 32'h3C);
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        check("led_at_store_edge", led, 8'h3C);
        @(posedge clk);
        #1;
        check("led_one_edge_later", led, 8'hA5);
        @(negedge clk);

        // ---------------- PWM duty, prescale 0 ----------------
        bus_write(32'h0001_000C, 32'd0);
        bus_write(32'h0001_0004, 32'h01);
        bus_write(32'h0001_0010, 32'd64);
        repeat (4) @(negedge clk);
        count_high(256, cnt);
        check("pwm_duty64", cnt, 64);

        bus_write(32'h0001_0010, 32'd0);
        repeat (4) @(negedge clk);
        count_high(256, cnt);
        check("pwm_duty0", cnt, 0);

        bus_write(32'h0001_0010, 32'd255);
        repeat (4) @(negedge clk);
        count_high(256, cnt);
        check("pwm_duty255", cnt, 255);

        // ---------------- prescaler ----------------
        bus_write(32'h0001_000C, 32'd3);
        bus_write(32'h0001_0010, 32'd128);
        repeat (8) @(negedge clk);
        count_high(1024, cnt);
        check("prescale3_duty128", cnt, 512);

        // With DUTY=1 the LED is high for one pwm step (4 cycles). Rewriting
        // PRESCALE one cycle into that step restarts the prescaler, stretching
        // the step to 6 cycles.
        bus_write(32'h0001_0010, 32'd1);
        found = 0;
        prev  = led[0];
        for (int g = 0; g < 3000 && found == 0; g++) begin
            @(negedge clk);
            if (led[0] && !prev) found = 1;
            prev = led[0];
        end
        check("restart_rise_seen", found, 1);
        cnt = 1;
        bus_write(32'h0001_000C, 32'd3);
        for (int g = 0; g < 20; g++) begin
            if (!led[0]) break;
            cnt++;
            @(negedge clk);
        end
        check("prescale_restart_width", cnt, 6);

        // ---------------- async reset mid-operation ----------------
        bus_write(32'h0001_000C, 32'd0);
        bus_write(32'h0001_0004, 32'hFF);
        for (int i = 0; i < 8; i++) bus_write(32'h0001_0010 + 32'(4 * i), 32'h80);
        found = 0;
        for (int g = 0; g < 600 && found == 0; g++) begin
            @(negedge clk);
            if (led != 8'h00) found = 1;
        end
        check("pwm_active_before_reset", found, 1);
        #2;
        reset = 1'b1;
        #1;
        check("led_async_reset", led, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        read_chk(32'h0001_0000, "post_reset_led_out", 32'h0);
        read_chk(32'h0001_0004, "post_reset_mode", 32'h0);
        read_chk(32'h0001_000C, "post_reset_prescale", 32'h0);
        read_chk(32'h0001_0010, "post_reset_duty0", 32'h0);
        read_chk(32'h0001_002C, "post_reset_duty7", 32'h0);
        @(negedge clk);
        found = 0;
        for (int g = 0; g < 20; g++) begin
            if (led != 8'h00) found++;
            @(negedge clk);
        end
        check("led_stays_off_after_reset", found, 0);

        // ---------------- blink ----------------
`ifdef LED_BLINK_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_write(32'h0001_0000, 32'h01);
        bus_write(32'h0001_0008, 32'h01);
        repeat (100) @(negedge clk);
        check("blink_first_half_off", led[0], 1'b0);
        repeat (2100) @(negedge clk);
        check("blink_second_half_on", led[0], 1'b1);
        count_high(4096, cnt);
        check("blink_duty_full_cycle", cnt, 2048);
`else
        read_chk(32'h0001_0008, "blink_unmapped", 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
